// File: rtl/multi_digit_counter_display_pkg.sv
// Shared constants for the multi-digit counter/display slice: digit width,
// seven-segment glyphs and the per-digit range clamp.
package multi_digit_counter_display_pkg;

  localparam int DIGIT_W = 4;

  // Segment order is A..G from bit 6 down to bit 0, active-high.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Digits outside the radix saturate to the largest legal digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                     input int radix);
    if (int'(value) >= radix) begin
      return DIGIT_W'(radix - 1);
    end
    return value;
  endfunction

endpackage

// File: rtl/multi_digit_counter_display_decoder.sv
// Combinational hex-to-seven-segment decoder, shared by every display position.
module seg7_hex_decoder
  import multi_digit_counter_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_counter_display.sv
// Cascaded N-digit up/down counter with wrap limit and load, driving a
// time-multiplexed seven-segment display with optional leading-zero blanking.
module multi_digit_counter_display
  import multi_digit_counter_display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int RADIX    = 10,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  direction,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [4*DIGITS-1:0]   max_count,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int W      = DIGITS * DIGIT_W;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGIT_W-1:0] TOP_DIGIT = DIGIT_W'(RADIX - 1);

  logic [W-1:0]         load_c;
  logic [W-1:0]         max_c;
  logic [W-1:0]         inc_val;
  logic [W-1:0]         dec_val;
  logic [W-1:0]         count_next;
  logic                 tc_next;
  logic [DIGITS-1:0]    carry;
  logic [DIGITS-1:0]    borrow;
  logic [DIGITS:0]      upper_zero;

  logic [SCAN_W-1:0]    scan_cnt;
  logic [SCAN_W-1:0]    scan_next;
  logic [IDX_W-1:0]     scan_idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 slot_end;
  logic [DIGIT_W-1:0]   mux_digit;
  logic                 blank_digit;
  logic [6:0]           glyph;
  logic [6:0]           seg_next;

  assign carry[0]           = 1'b1;
  assign borrow[0]          = 1'b1;
  assign upper_zero[DIGITS] = 1'b1;

  // Per-digit clamping plus the ripple carry/borrow chains.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] d;
    assign d = count[i*DIGIT_W +: DIGIT_W];

    assign load_c[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_value[i*DIGIT_W +: DIGIT_W], RADIX);
    assign max_c[i*DIGIT_W +: DIGIT_W]  = clamp_digit(max_count[i*DIGIT_W +: DIGIT_W], RADIX);

    assign inc_val[i*DIGIT_W +: DIGIT_W] = !carry[i]  ? d :
                                           ((d == TOP_DIGIT) ? '0 : d + DIGIT_W'(1));
    assign dec_val[i*DIGIT_W +: DIGIT_W] = !borrow[i] ? d :
                                           ((d == '0) ? TOP_DIGIT : d - DIGIT_W'(1));

    if (i < DIGITS - 1) begin : g_chain
      assign carry[i+1]  = carry[i]  & (d == TOP_DIGIT);
      assign borrow[i+1] = borrow[i] & (d == '0);
    end

    assign upper_zero[i] = upper_zero[i+1] & (count_next[i*DIGIT_W +: DIGIT_W] == '0);
  end

  // Packed digits compare numerically, so count >= M covers both the
  // normal terminal value and an out-of-range value left by a load.
  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    if (load) begin
      count_next = load_c;
    end else if (enable) begin
      if (direction) begin
        if (count >= max_c) begin
          count_next = '0;
          tc_next    = 1'b1;
        end else begin
          count_next = inc_val;
        end
      end else begin
        if (count == '0) begin
          count_next = max_c;
          tc_next    = 1'b1;
        end else begin
          count_next = dec_val;
        end
      end
    end
  end

  always_comb begin
    slot_end  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    scan_next = slot_end ? '0 : scan_cnt + SCAN_W'(1);
    idx_next  = scan_idx;
    if (slot_end) begin
      idx_next = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  // Decode from next-state values so the registered seg matches the
  // registered count and digit_sel in the same cycle.
  always_comb begin
    mux_digit   = '0;
    blank_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        mux_digit   = count_next[i*DIGIT_W +: DIGIT_W];
        blank_digit = blank_lz && (i != 0) && upper_zero[i];
      end
    end
  end

  seg7_hex_decoder u_decoder (
    .value (mux_digit),
    .seg   (glyph)
  );

  assign seg_next = blank_digit ? SEG_BLANK : glyph;

  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      tc        <= 1'b0;
      scan_cnt  <= '0;
      scan_idx  <= '0;
      digit_sel <= DIGITS'(1);
      seg       <= SEG_0;
    end else begin
      count     <= count_next;
      tc        <= tc_next;
      scan_cnt  <= scan_next;
      scan_idx  <= idx_next;
      digit_sel <= DIGITS'(1) << idx_next;
      seg       <= seg_next;
    end
  end

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Self-checking bench: numeric reference model of counter and scan compared
// every cycle, plus directed literal checks and a randomized soak.
module tb_multi_digit_counter_display;

  localparam int DIGITS   = 4;
  localparam int RADIX    = 10;
  localparam int SCAN_DIV = 4;
  localparam int W        = 4 * DIGITS;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              direction = 1'b1;
  logic              load = 1'b0;
  logic [W-1:0]      load_value = '0;
  logic [W-1:0]      max_count = '0;
  logic              blank_lz = 1'b0;
  logic [W-1:0]      count;
  logic              tc;
  logic [6:0]        seg;
  logic [DIGITS-1:0] digit_sel;

  int passes = 0;
  int total  = 0;
  bit check_en = 1'b0;

  int m_val   = 0;
  bit m_tc    = 1'b0;
  int m_n     = 0;
  bit m_blank = 1'b0;

  multi_digit_counter_display #(
    .DIGITS   (DIGITS),
    .RADIX    (RADIX),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .direction  (direction),
    .load       (load),
    .load_value (load_value),
    .max_count  (max_count),
    .blank_lz   (blank_lz),
    .count      (count),
    .tc         (tc),
    .seg        (seg),
    .digit_sel  (digit_sel)
  );

  always #5 clock = ~clock;

  function automatic int pow_r(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * RADIX;
    return p;
  endfunction

  function automatic int to_val(input logic [W-1:0] p);
    int v = 0;
    int d;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(p[i*4 +: 4]);
      if (d >= RADIX) d = RADIX - 1;
      v = v * RADIX + d;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_packed(input int v);
    logic [W-1:0] p = '0;
    int r = v;
    for (int i = 0; i < DIGITS; i++) begin
      p[i*4 +: 4] = 4'(r % RADIX);
      r = r / RADIX;
    end
    return p;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: the counter is a plain integer in 0..RADIX^DIGITS-1.
  always @(posedge clock) begin
    if (reset) begin
      m_val = 0;
      m_tc  = 1'b0;
      m_n   = 0;
    end else begin
      m_n++;
      m_tc = 1'b0;
      if (load) begin
        m_val = to_val(load_value);
      end else if (enable) begin
        if (direction) begin
          if (m_val >= to_val(max_count)) begin
            m_val = 0;
            m_tc  = 1'b1;
          end else begin
            m_val = m_val + 1;
          end
        end else begin
          if (m_val == 0) begin
            m_val = to_val(max_count);
            m_tc  = 1'b1;
          end else begin
            m_val = m_val - 1;
          end
        end
      end
    end
    m_blank = blank_lz && !reset;
  end

  always @(negedge clock) begin
    int k;
    logic [6:0] exp_seg;
    if (check_en) begin
      k = (m_n / SCAN_DIV) % DIGITS;
      exp_seg = GLYPH[(m_val / pow_r(k)) % RADIX];
      if (m_blank && k != 0 && m_val < pow_r(k)) exp_seg = 7'b0;
      check_output("model_count", 32'(count), 32'(to_packed(m_val)));
      check_output("model_tc", 32'(tc), 32'(m_tc));
      check_output("model_digit_sel", 32'(digit_sel), 32'(1) << k);
      check_output("model_seg", 32'(seg), 32'(exp_seg));
    end
  end

  task automatic apply_stimulus(input bit en, input bit dir, input bit ld,
                                input logic [W-1:0] lv, input logic [W-1:0] mx,
                                input int cycles);
    enable     = en;
    direction  = dir;
    load       = ld;
    load_value = lv;
    max_count  = mx;
    repeat (cycles) @(negedge clock);
  endtask

  initial begin
    int tc_seen;
    bit found;

    repeat (2) @(negedge clock);
    reset    = 1'b0;
    check_en = 1'b1;
    check_output("reset_count", 32'(count), 32'h0);
    check_output("reset_tc", 32'(tc), 32'h0);
    check_output("reset_digit_sel", 32'(digit_sel), 32'h1);
    check_output("reset_seg", 32'(seg), 32'b1111110);

    enable    = 1'b1;
    direction = 1'b1;
    max_count = 16'h0099;
    tc_seen   = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (tc) tc_seen++;
    end
    check_output("up12_count", 32'(count), 32'h0012);
    check_output("up12_no_tc", 32'(tc_seen), 32'h0);

    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h0098, 16'h0099, 1);
    check_output("load_98", 32'(count), 32'h0098);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0099, 1);
    check_output("up_to_99", 32'(count), 32'h0099);
    check_output("up_to_99_tc", 32'(tc), 32'h0);
    @(negedge clock);
    check_output("wrap_count", 32'(count), 32'h0000);
    check_output("wrap_tc", 32'(tc), 32'h1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0099, 1);
    check_output("after_wrap_tc", 32'(tc), 32'h0);

    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0025, 1);
    check_output("down_wrap_count", 32'(count), 32'h0025);
    check_output("down_wrap_tc", 32'(tc), 32'h1);
    @(negedge clock);
    check_output("down_step_count", 32'(count), 32'h0024);
    check_output("down_step_tc", 32'(tc), 32'h0);

    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h003F, 16'h0020, 1);
    check_output("load_clamp", 32'(count), 32'h0039);
    apply_stimulus(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0020, 1);
    check_output("over_max_count", 32'(count), 32'h0000);
    check_output("over_max_tc", 32'(tc), 32'h1);

    // Align the scan to a known phase, then load 0107 with blanking on.
    enable = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    blank_lz = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h0107, 16'h0099, 1);
    load = 1'b0;
    repeat (2) @(negedge clock);
    check_output("scan0_sel", 32'(digit_sel), 32'b0001);
    check_output("scan0_seg", 32'(seg), 32'b1110000);
    repeat (4) @(negedge clock);
    check_output("scan1_sel", 32'(digit_sel), 32'b0010);
    check_output("scan1_seg", 32'(seg), 32'b1111110);
    repeat (4) @(negedge clock);
    check_output("scan2_sel", 32'(digit_sel), 32'b0100);
    check_output("scan2_seg", 32'(seg), 32'b0110000);
    repeat (4) @(negedge clock);
    check_output("scan3_sel", 32'(digit_sel), 32'b1000);
    check_output("scan3_seg", 32'(seg), 32'b0000000);

    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h0050, 16'h0099, 1);
    check_output("load_beats_enable", 32'(count), 32'h0050);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0099, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (digit_sel == 4'b0100) found = 1'b1;
    end
    check_output("wait_slot2", 32'(found), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_output("midscan_reset_count", 32'(count), 32'h0);
    check_output("midscan_reset_sel", 32'(digit_sel), 32'b0001);
    check_output("midscan_reset_seg", 32'(seg), 32'b1111110);

    // Randomized soak; small wrap limits keep terminal counts frequent.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] mx;
      mx = {8'h00, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 7) == 0) mx = 16'($urandom);
      if ($urandom_range(0, 15) == 0 || i == 0) max_count = mx;
      reset      = ($urandom_range(0, 199) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_value = 16'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) direction = ~direction;
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      @(negedge clock);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
